// File: rtl/pipeline_pkg.sv
// Shared ID/EX pipeline types: the decoded bundle layout, its NOP value and ALU opcodes.
package pipeline_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] PC;
      logic [ADDR_WIDTH-1:0] PCPlus4;
      logic [DATA_WIDTH-1:0] RD1;
      logic [DATA_WIDTH-1:0] RD2;
      logic [4:0]            Rs1;
      logic [4:0]            Rs2;
      logic [4:0]            Rd;
      logic [DATA_WIDTH-1:0] ImmExt;
      logic                  RegWrite;
      logic [1:0]            ResultSrc;
      logic                  MemWrite;
      logic                  Jump;
      logic                  Branch;
      logic [3:0]            ALUControl;
      logic                  ALUSrc;
   } id_ex_t;

   localparam id_ex_t ID_EX_NOP = '0;
   localparam int     ID_EX_W   = $bits(id_ex_t);

endpackage

// File: rtl/decode_execute_reg_skid.sv
// Generic 2-entry elastic buffer: entry0 is the head, entry1 the tail; ready depends only on
// the registered count so upstream never sees a combinational path from downstream ready.
module skid_buf2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count
);

   logic [1:0]   r_count;
   logic [W-1:0] r_entry0;
   logic [W-1:0] r_entry1;
   logic         w_push;
   logic         w_pop;

   assign o_ready = (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_entry0;
   assign o_count = r_count;
   assign w_push  = i_valid & o_ready & ~i_flush;
   assign w_pop   = o_valid & i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= 2'd0;
         r_entry0 <= '0;
         r_entry1 <= '0;
      end else if (i_flush) begin
         // A pop this cycle still completes downstream; only held state is discarded.
         r_count  <= 2'd0;
         r_entry0 <= '0;
         r_entry1 <= '0;
      end else begin
         case (r_count)
            2'd0: begin
               if (w_push) begin
                  r_count  <= 2'd1;
                  r_entry0 <= i_data;
               end
            end
            2'd1: begin
               case ({w_push, w_pop})
                  2'b11: r_entry0 <= i_data;
                  2'b10: begin
                     r_count  <= 2'd2;
                     r_entry1 <= i_data;
                  end
                  2'b01: begin
                     r_count  <= 2'd0;
                     r_entry0 <= '0;
                  end
                  default: ;
               endcase
            end
            2'd2: begin
               if (w_pop) begin
                  r_count  <= 2'd1;
                  r_entry0 <= r_entry1;
                  r_entry1 <= '0;
               end
            end
            default: begin
               r_count  <= 2'd0;
               r_entry0 <= '0;
               r_entry1 <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/decode_execute_reg.sv
// Elastic ID/EX stage: 2-entry skid buffer between Decode and Execute, presenting a zeroed
// NOP bundle to Execute whenever nothing is held.
module decode_execute_reg
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               FlushE,
   input  logic               ValidD,
   output logic               ReadyD,
   input  logic [ID_EX_W-1:0] BundleD,
   output logic               ValidE,
   input  logic               ReadyE,
   output logic [ID_EX_W-1:0] BundleE,
   output logic [1:0]         OccupancyE
);

   generate
      if (DEPTH != 2) begin : g_bad_depth
         $error("decode_execute_reg: only DEPTH=2 is supported");
      end
      if (DATA_WIDTH != pipeline_pkg::DATA_WIDTH || ADDR_WIDTH != pipeline_pkg::ADDR_WIDTH) begin : g_bad_width
         $error("decode_execute_reg: widths must match pipeline_pkg id_ex_t");
      end
   endgenerate

   logic               w_valid;
   logic [ID_EX_W-1:0] w_head;

   skid_buf2 #(.W(ID_EX_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_flush (FlushE),
      .i_valid (ValidD),
      .o_ready (ReadyD),
      .i_data  (BundleD),
      .o_valid (w_valid),
      .i_ready (ReadyE),
      .o_data  (w_head),
      .o_count (OccupancyE)
   );

   // Gate explicitly so a stale head can never leak control bits into Execute.
   assign ValidE  = w_valid;
   assign BundleE = w_valid ? w_head : ID_EX_NOP;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for decode_execute_reg: directed scenarios followed by a long random run.
module tb_decode_execute_reg;
   import pipeline_pkg::*;

   logic               clk;
   logic               rst;
   logic               FlushE;
   logic               ValidD;
   logic               ReadyD;
   id_ex_t             BundleD;
   logic               ValidE;
   logic               ReadyE;
   logic [ID_EX_W-1:0] BundleE;
   logic [1:0]         OccupancyE;

   int n_cmp = 0;
   int n_bad = 0;
   id_ex_t exp_q[$];

   decode_execute_reg #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .FlushE     (FlushE),
      .ValidD     (ValidD),
      .ReadyD     (ReadyD),
      .BundleD    (BundleD),
      .ValidE     (ValidE),
      .ReadyE     (ReadyE),
      .BundleE    (BundleE),
      .OccupancyE (OccupancyE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic id_ex_t mk(input logic [31:0] imm, input logic [7:0] tag);
      id_ex_t b;
      b            = '0;
      b.PC         = 32'h0000_1000 + {22'd0, tag, 2'b00};
      b.PCPlus4    = b.PC + 32'd4;
      b.RD1        = {24'hA0A0A0, tag};
      b.RD2        = {24'hB0B0B0, tag};
      b.Rs1        = tag[4:0];
      b.Rs2        = tag[4:0] ^ 5'h1F;
      b.Rd         = tag[4:0] + 5'd1;
      b.ImmExt     = imm;
      b.RegWrite   = 1'b1;
      b.MemWrite   = tag[0];
      b.Jump       = tag[1];
      b.Branch     = tag[2];
      b.ALUControl = ALU_SUB;
      b.ALUSrc     = 1'b1;
      return b;
   endfunction

   task automatic cyc(input logic v, input id_ex_t b, input logic re, input logic fl, input logic rs);
      ValidD  = v;
      BundleD = b;
      ReadyE  = re;
      FlushE  = fl;
      rst     = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
      end
   endtask

   // Monitor and reference queue: outputs are checked against the model held since the last
   // edge, then the model advances using the inputs that the next edge will sample.
   initial begin
      int sz;
      @(posedge clk);
      forever begin
         @(negedge clk);
         sz = exp_q.size();
         chk("OccupancyE", 256'(OccupancyE), 256'(sz));
         chk("ReadyD", 256'(ReadyD), 256'(sz != 2));
         chk("ValidE", 256'(ValidE), 256'(sz != 0));
         if (sz == 0) chk("BundleE_nop", 256'(BundleE), 256'(ID_EX_NOP));
         else         chk("BundleE_head", 256'(BundleE), 256'(exp_q[0]));
         if (rst) begin
            exp_q.delete();
         end else begin
            if (sz != 0 && ReadyE) void'(exp_q.pop_front());
            if (FlushE)                  exp_q.delete();
            else if (ValidD && sz != 2)  exp_q.push_back(BundleD);
         end
      end
   end

   initial begin
      id_ex_t a, b, c, d, z;
      logic [223:0] raw;
      z = '0;
      a = mk(32'hDEAD_0001, 8'h11);
      b = mk(32'hDEAD_0002, 8'h22);
      c = mk(32'hDEAD_0003, 8'h33);
      d = mk(32'hDEAD_0004, 8'h47);

      // reset held with Decode offering a bundle
      cyc(1, a, 0, 0, 1);
      cyc(1, a, 0, 0, 1);

      // streaming, one bundle per cycle through a single entry
      cyc(1, mk(32'hFFFF_F800, 8'h01), 1, 0, 0);
      cyc(1, mk(32'h0000_0004, 8'h02), 1, 0, 0);
      cyc(1, mk(32'h000F_F000, 8'h03), 1, 0, 0);
      cyc(0, z, 1, 0, 0);
      cyc(0, z, 1, 0, 0);

      // back-pressure: fill, drain, C accepted when ReadyD returns
      cyc(1, a, 0, 0, 0);
      cyc(1, b, 0, 0, 0);
      cyc(1, c, 0, 0, 0);
      cyc(1, c, 1, 0, 0);
      cyc(1, c, 1, 0, 0);
      cyc(0, z, 1, 0, 0);
      cyc(0, z, 1, 0, 0);

      // flush while full, D offered the same cycle
      cyc(1, a, 0, 0, 0);
      cyc(1, b, 0, 0, 0);
      cyc(1, d, 0, 1, 0);
      cyc(0, z, 1, 0, 0);
      cyc(0, z, 1, 0, 0);

      // simultaneous push and pop at one entry
      cyc(1, a, 0, 0, 0);
      cyc(1, b, 1, 0, 0);
      cyc(1, c, 1, 0, 0);
      cyc(0, z, 1, 0, 0);

      // reset mid-operation, with flush and a push also requested
      cyc(1, a, 0, 0, 0);
      cyc(1, b, 0, 0, 0);
      cyc(1, d, 1, 1, 1);
      cyc(0, z, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         for (int k = 0; k < 7; k++) raw[k*32 +: 32] = $urandom;
         cyc(($urandom_range(0, 9) < 7), id_ex_t'(raw[ID_EX_W-1:0]),
             ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 255) == 0));
      end
      cyc(0, z, 1, 0, 0);
      cyc(0, z, 1, 0, 0);
      cyc(0, z, 1, 0, 0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
